// File: rtl/sad_min_tracker_pkg.sv
// Shared motion-estimation types: SAD/position widths, tracker state encoding
// and the candidate record kept per sub-block.
package me_pkg;
  localparam int SAD_W  = 16;
  localparam int COL_W  = 5;
  localparam int ROW_W  = 7;
  localparam int NUM_CB = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             hit;
  } mv_cand_t;
endpackage

// File: rtl/sad_min_cell.sv
// One sub-block's best candidate: keeps the smallest SAD seen since the last
// clear, together with the search position where it first appeared.
module sad_min_cell #(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd_en,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [COL_W-1:0] sad_col,
  input  logic [ROW_W-1:0] sad_row,
  output logic [SAD_W-1:0] cand_sad,
  output logic [COL_W-1:0] cand_col,
  output logic [ROW_W-1:0] cand_row,
  output logic             cand_hit
);

  // Strict less-than keeps the earliest position on ties; the first SAD always
  // lands, even an all-ones one, so hit separates "saw max SAD" from "saw nothing".
  logic take;
  assign take = upd_en && (!cand_hit || (sad_in < cand_sad));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cand_sad <= '1;
      cand_col <= '0;
      cand_row <= '0;
      cand_hit <= 1'b0;
    end else if (take) begin
      cand_sad <= sad_in;
      cand_col <= sad_col;
      cand_row <= sad_row;
      cand_hit <= 1'b1;
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the per-sub-block minimum SAD over one search and then streams the
// four best motion candidates out over a valid/ready interface.
module sad_min_tracker #(
  parameter int SAD_W = me_pkg::SAD_W,
  parameter int COL_W = me_pkg::COL_W,
  parameter int ROW_W = me_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [COL_W-1:0] sad_col,
  input  logic [ROW_W-1:0] sad_row,
  input  logic             search_done,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_cb,
  output logic [SAD_W-1:0] res_sad,
  output logic [COL_W-1:0] res_col,
  output logic [ROW_W-1:0] res_row,
  output logic             res_empty,
  output logic             res_last,
  output logic             done
);
  import me_pkg::*;

  state_t     state, state_nxt;
  logic [1:0] beat, beat_nxt;
  logic       done_nxt;
  logic       clr;
  logic       trk_upd;

  logic [SAD_W-1:0] c_sad [NUM_CB];
  logic [COL_W-1:0] c_col [NUM_CB];
  logic [ROW_W-1:0] c_row [NUM_CB];
  logic             c_hit [NUM_CB];

  // A restart pulse wins over a same-cycle SAD, which is dropped.
  assign trk_upd = (state == ST_TRACK) && sad_valid && !start;

  for (genvar i = 0; i < NUM_CB; i++) begin : g_cell
    sad_min_cell #(
      .SAD_W(SAD_W),
      .COL_W(COL_W),
      .ROW_W(ROW_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .upd_en  (trk_upd && (sad_cb == 2'(i))),
      .sad_in  (sad_in),
      .sad_col (sad_col),
      .sad_row (sad_row),
      .cand_sad(c_sad[i]),
      .cand_col(c_col[i]),
      .cand_row(c_row[i]),
      .cand_hit(c_hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      beat  <= 2'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    done_nxt  = 1'b0;
    clr       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (start) begin
          clr = 1'b1;
        end else if (search_done) begin
          state_nxt = ST_REPORT;
          beat_nxt  = 2'd0;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          if (beat == 2'd3) begin
            state_nxt = ST_IDLE;
            beat_nxt  = 2'd0;
            done_nxt  = 1'b1;
          end else begin
            beat_nxt = beat + 2'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result fields are forced to zero outside REPORT so idle outputs stay quiet.
  always_comb begin
    busy      = (state != ST_IDLE);
    res_valid = (state == ST_REPORT);
    res_cb    = '0;
    res_sad   = '0;
    res_col   = '0;
    res_row   = '0;
    res_empty = 1'b0;
    res_last  = 1'b0;
    if (res_valid) begin
      res_cb    = beat;
      res_sad   = c_sad[beat];
      res_col   = c_col[beat];
      res_row   = c_row[beat];
      res_empty = ~c_hit[beat];
      res_last  = (beat == 2'd3);
    end
  end

endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Downstream of the PE array in the DMT motion-estimation datapath.
- Consumes one SAD per cycle, tagged with its sub-block id (the PE array's abs_Control) and its search position (search_column_count, search_row_count).
- Keeps the running minimum SAD and its position for each of the 4 sub-blocks, and on search completion reports the 4 best motion candidates over a valid/ready stream.

Parameters:
- SAD_W, 16, width of one SAD value.
- COL_W, 5, width of the search column index.
- ROW_W, 7, width of the search row index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: clear all minima, enter TRACK
- sad_valid  in  1  sad_in and its tags valid this cycle
- sad_cb  in  2  sub-block id, 0..3
- sad_in  in  SAD_W  SAD value
- sad_col  in  COL_W  search column of this SAD
- sad_row  in  ROW_W  search row of this SAD
- search_done  in  1  one-cycle pulse: last SAD has been presented
- busy  out  1  high in TRACK and REPORT
- res_valid  out  1  result beat valid
- res_ready  in  1  consumer accepts beat
- res_cb  out  2  sub-block id of beat
- res_sad  out  SAD_W  minimum SAD
- res_col  out  COL_W  column of minimum
- res_row  out  ROW_W  row of minimum
- res_empty  out  1  no SAD was received for this sub-block
- res_last  out  1  high on the cb=3 beat
- done  out  1  one-cycle pulse after the last beat handshakes

Behaviour:
- Reset values:
  - State: IDLE.
  - Outputs: busy=0, res_valid=0, res_cb=0, res_sad=0, res_col=0, res_row=0, res_empty=0, res_last=0, done=0.
  - Internal: min_sad[0..3]=all-ones, min_col=0, min_row=0, hit[0..3]=0.
- States: IDLE, TRACK, REPORT.
- IDLE:
  - On start: clear min_sad to all-ones, clear hit, clear positions, then go to TRACK.
  - sad_valid and search_done are ignored.
- TRACK:
  - On sad_valid with (sad_in < min_sad[sad_cb]) or hit[sad_cb]==0: next cycle min_sad, min_col and min_row for that sub-block take sad_in, sad_col and sad_row; hit[sad_cb] is set.
  - Tie rule: a SAD equal to the current minimum does not replace it. The earliest position wins.
  - An all-ones SAD still sets hit and records its position.
  - Update latency is 1 cycle; back-to-back updates to the same sub-block are supported every cycle.
  - On search_done: any SAD presented in the same cycle is included. Next state is REPORT with beat index 0.
  - start while in TRACK: clear and stay in TRACK (restart). The same-cycle SAD is discarded.
- REPORT:
  - Beat index k runs 0..3.
  - res_valid=1, res_cb=k, with res_sad, res_col and res_row taken from sub-block k.
  - res_empty = ~hit[k]. An empty beat reports sad all-ones and col/row 0.
  - res_last = (k==3).
  - Outputs hold stable while res_valid=1 and res_ready=0.
  - Handshake is res_valid && res_ready. It advances k; on k==3 the next state is IDLE and done=1 for that next cycle.
  - First beat is valid in the cycle after the search_done cycle.
  - sad_valid, search_done and start are ignored in REPORT.
- rst mid-operation: return to the reset values immediately on the next edge. No partial report is emitted.
- Comparison is unsigned at full SAD_W. No accumulation, so no overflow is possible.

Decomposition:
- Shared package me_pkg:
  - SAD_W, COL_W, ROW_W constants.
  - NUM_CB=4.
  - State encoding typedef (IDLE/TRACK/REPORT).
  - Struct mv_cand_t {sad, col, row, hit}.
- Natural sub-module: sad_min_cell. One per sub-block, 4 instances. Holds a single candidate and contains the compare/update and clear logic.
- Top level: FSM, cb decode, output mux.

Test Plan:
- Basic minimum:
  - Stimulus: start; cb0 SADs 500@(1,0), 300@(1,5), 400@(2,3); search_done.
  - Required: beat0 sad=300, col=1, row=5, empty=0; beats 1-3 empty=1, sad=0xFFFF; res_last on beat3; done one cycle after beat3 handshakes.
- Tie and interleaving:
  - Stimulus: cb1 200@(3,4), cb2 90@(3,4), cb1 200@(4,0), cb1 199@(5,9), all on consecutive cycles.
  - Required: cb1 result=199@(5,9); cb2 result=90@(3,4); the equal 200 does not replace (3,4) before the 199 arrives.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles during beat 2, then drive 1.
  - Required: beat 2 fields constant throughout the stall; beat 3 follows; exactly 4 handshakes; one done pulse.
- Boundary:
  - Stimulus: search_done in the same cycle as sad_valid cb3 10@(31,127).
  - Required: cb3 reports 10 with col=31, row=127.
  - Stimulus: single SAD 0xFFFF on cb0.
  - Required: empty=0, position recorded.
- Restart and reset:
  - Stimulus: start mid-TRACK after cb0 5@(1,1), then cb0 50@(2,2), search_done.
  - Required: cb0=50@(2,2).
  - Stimulus: rst asserted during REPORT beat 1.
  - Required: next cycle res_valid=0, busy=0, no done pulse.
- Idle ignore:
  - Stimulus: sad_valid and search_done pulses in IDLE.
  - Required: no state change, res_valid stays 0; a subsequent start/search_done gives all-empty beats.
